// File: rtl/ir_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ir_prefetch_queue
// Description : Instruction register with a small prefetch queue. Fields of
//               one instruction arrive one per MDR word and are assembled
//               (field 0 = opcode, then operands). Each completed instruction
//               is written into a DEPTH-slot circular queue. The control unit
//               consumes the head instruction through a valid/ready
//               handshake. A synchronous flush discards the queue and any
//               partially assembled instruction (branch redirect).
//
// Ports       : clk         - system clock, rising edge
//               reset_n     - asynchronous active-low reset
//               mdr         - incoming instruction field (DATA_W)
//               mdr_valid   - mdr holds a field to load
//               mdr_ready   - block accepts mdr this cycle
//               flush       - synchronous discard of queue and assembly
//               opcode      - field 0 of head instruction (0 when empty)
//               operands    - fields 1..FIELDS-1 of head, field 1 in LSBs
//               instr_valid - head instruction present
//               instr_ready - consumer takes head instruction
//               count       - number of complete instructions held
//               partial     - fields of an instruction are pending
//
// Revision    : 1.0 - initial release
// ============================================================================
module ir_prefetch_queue #(
   parameter int DATA_W = 8,
   parameter int FIELDS = 2,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [DATA_W-1:0]            mdr,
   input  logic                         mdr_valid,
   output logic                         mdr_ready,
   input  logic                         flush,
   output logic [DATA_W-1:0]            opcode,
   output logic [(FIELDS-1)*DATA_W-1:0] operands,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         partial
);

   localparam int IDX_W  = $clog2(FIELDS);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int WORD_W = FIELDS*DATA_W;

   localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(FIELDS-1);
   localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);

   // Assembly state
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_asm [FIELDS-1];

   // Queue state
   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_last;
   logic              w_full;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic [WORD_W-1:0] w_word;
   logic [WORD_W-1:0] w_head;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   assign w_last   = (r_idx == c_IDX_LAST);
   assign w_full   = (r_count == c_DEPTH);
   // Only the final field needs a free slot; earlier fields go into the
   // assembly registers and may be taken while the queue is full. The pop
   // side is deliberately not consulted, keeping mdr_ready free of any
   // combinational path from instr_ready.
   assign mdr_ready   = !(w_last && w_full);
   assign w_accept    = mdr_valid && mdr_ready;
   assign w_push      = w_accept && w_last;
   assign instr_valid = (r_count != '0);
   assign w_pop       = instr_valid && instr_ready;

   // ------------------------------------------------------------------------
   // Completed instruction word: stored fields plus the live mdr as the last
   // field, so the instruction is enqueued on the edge its final field lands.
   // Field k occupies bits [k*DATA_W +: DATA_W].
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < FIELDS-1; gi++) begin : g_pack
         assign w_word[gi*DATA_W +: DATA_W] = r_asm[gi];
      end
   endgenerate
   assign w_word[(FIELDS-1)*DATA_W +: DATA_W] = mdr;

   // ------------------------------------------------------------------------
   // Control state: index, pointers, occupancy. Flush outranks everything.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx   <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_idx   <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_accept) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
         end
         // DEPTH is a power of two, so pointers wrap naturally.
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Data storage (no reset; contents are qualified by idx/count)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!flush) begin
         for (int i = 0; i < FIELDS-1; i++) begin
            if (w_accept && (r_idx == IDX_W'(i))) begin
               r_asm[i] <= mdr;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!flush && w_push) begin
         r_mem[r_wptr] <= w_word;
      end
   end

   // ------------------------------------------------------------------------
   // Head presentation: zeroed when the queue is empty so stale slot contents
   // never reach the decoder.
   // ------------------------------------------------------------------------
   assign w_head   = r_mem[r_rptr];
   assign opcode   = instr_valid ? w_head[DATA_W-1:0]      : '0;
   assign operands = instr_valid ? w_head[WORD_W-1:DATA_W] : '0;
   assign count    = r_count;
   assign partial  = (r_idx != '0);

endmodule
`default_nettype wire

// File: tb/tb_ir_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_prefetch_queue
// Description : Scoreboard bench for ir_prefetch_queue (DATA_W=8, FIELDS=2,
//               DEPTH=4). Stimulus tasks push expected instructions into a
//               queue; a monitor pops and compares on every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_prefetch_queue;

   localparam int DATA_W = 8;
   localparam int FIELDS = 2;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic                         clk;
   logic                         reset_n;
   logic [DATA_W-1:0]            mdr;
   logic                         mdr_valid;
   logic                         mdr_ready;
   logic                         flush;
   logic [DATA_W-1:0]            opcode;
   logic [(FIELDS-1)*DATA_W-1:0] operands;
   logic                         instr_valid;
   logic                         instr_ready;
   logic [CNT_W-1:0]             count;
   logic                         partial;

   int n_checks = 0;
   int n_errors = 0;
   int n_pops   = 0;
   int max_cnt  = 0;
   logic [15:0] exp_q [$];

   ir_prefetch_queue #(.DATA_W(DATA_W), .FIELDS(FIELDS), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mdr         (mdr),
      .mdr_valid   (mdr_valid),
      .mdr_ready   (mdr_ready),
      .flush       (flush),
      .opcode      (opcode),
      .operands    (operands),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .count       (count),
      .partial     (partial)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens on the next rising edge whenever valid & ready
   // are both high with no flush and reset released.
   always @(negedge clk) begin
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (reset_n && !flush && instr_valid && instr_ready) begin
         n_pops++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got 0x%0h%0h expected none", opcode, operands);
         end else begin
            chk("sb_head", {opcode, operands}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic send_field(input logic [7:0] d);
      mdr       = d;
      mdr_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (mdr_ready) begin
            @(posedge clk); #1;
            mdr_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      mdr_valid = 1'b0;
      chk("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic send_instr(input logic [7:0] op, input logic [7:0] opd);
      send_field(op);
      send_field(opd);
      exp_q.push_back({op, opd});
   endtask

   task automatic drain();
      instr_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (count == '0) break;
         @(posedge clk); #1;
      end
      instr_ready = 1'b0;
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_sb_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      int pops0;
      reset_n     = 1'b0;
      mdr         = '0;
      mdr_valid   = 1'b0;
      flush       = 1'b0;
      instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_partial", 32'(partial), 32'd0);
      chk("rst_opcode", 32'(opcode), 32'd0);
      chk("rst_mdr_ready", 32'(mdr_ready), 32'd1);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // --- single instruction -------------------------------------------
      send_field(8'h3A);
      chk("t1_partial_mid", 32'(partial), 32'd1);
      chk("t1_opcode_mid", 32'(opcode), 32'd0);
      chk("t1_valid_mid", 32'(instr_valid), 32'd0);
      send_field(8'h05);
      exp_q.push_back(16'h3A05);
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_opcode", 32'(opcode), 32'h3A);
      chk("t1_operands", 32'(operands), 32'h05);
      chk("t1_count", 32'(count), 32'd1);
      chk("t1_partial", 32'(partial), 32'd0);
      drain();

      // --- fill and back-pressure --------------------------------------
      for (int i = 0; i < 4; i++) send_instr(8'h10 + 8'(i), 8'hA0 + 8'(i));
      chk("t2_count_full", 32'(count), 32'd4);
      chk("t2_ready_idx0", 32'(mdr_ready), 32'd1);
      send_field(8'h14);
      chk("t2_partial", 32'(partial), 32'd1);
      chk("t2_ready_blocked", 32'(mdr_ready), 32'd0);
      mdr = 8'hA4; mdr_valid = 1'b1;
      @(posedge clk); #1;
      chk("t2_stall_count", 32'(count), 32'd4);
      chk("t2_stall_partial", 32'(partial), 32'd1);
      instr_ready = 1'b1;
      @(posedge clk); #1;
      instr_ready = 1'b0;
      chk("t2_pop_count", 32'(count), 32'd3);
      chk("t2_ready_freed", 32'(mdr_ready), 32'd1);
      @(posedge clk); #1;
      mdr_valid = 1'b0;
      exp_q.push_back(16'h14A4);
      chk("t2_refill_count", 32'(count), 32'd4);
      chk("t2_refill_partial", 32'(partial), 32'd0);
      chk("t2_head", 32'(opcode), 32'h11);
      drain();

      // --- simultaneous push and pop -----------------------------------
      send_instr(8'h50, 8'h51);
      send_instr(8'h60, 8'h61);
      send_field(8'h70);
      mdr = 8'h71; mdr_valid = 1'b1; instr_ready = 1'b1;
      @(posedge clk); #1;
      mdr_valid = 1'b0; instr_ready = 1'b0;
      exp_q.push_back(16'h7071);
      chk("t3_count", 32'(count), 32'd2);
      chk("t3_head_op", 32'(opcode), 32'h60);
      chk("t3_head_opd", 32'(operands), 32'h61);
      drain();

      // --- wrap-around streaming ---------------------------------------
      pops0   = n_pops;
      max_cnt = 0;
      instr_ready = 1'b1;
      for (int i = 0; i < 10; i++) send_instr(8'h80 + 8'(i), 8'hC0 + 8'(i));
      drain();
      chk("t4_pops", 32'(n_pops - pops0), 32'd10);
      chk("t4_max_count", 32'(max_cnt), 32'd1);

      // --- flush mid-assembly ------------------------------------------
      send_instr(8'h20, 8'h21);
      send_instr(8'h30, 8'h31);
      send_field(8'h22);
      mdr = 8'h99; mdr_valid = 1'b1; instr_ready = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; mdr_valid = 1'b0; instr_ready = 1'b0;
      exp_q.delete();
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_valid", 32'(instr_valid), 32'd0);
      chk("t5_partial", 32'(partial), 32'd0);
      chk("t5_opcode", 32'(opcode), 32'd0);
      send_instr(8'h40, 8'h01);
      chk("t5_new_op", 32'(opcode), 32'h40);
      chk("t5_new_opd", 32'(operands), 32'h01);
      drain();

      // --- asynchronous reset mid-operation ----------------------------
      send_instr(8'hB0, 8'hB1);
      send_instr(8'hB2, 8'hB3);
      send_instr(8'hB4, 8'hB5);
      send_field(8'hB6);
      chk("t6_pre_count", 32'(count), 32'd3);
      chk("t6_pre_partial", 32'(partial), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      chk("t6_valid", 32'(instr_valid), 32'd0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_partial", 32'(partial), 32'd0);
      chk("t6_opcode", 32'(opcode), 32'd0);
      chk("t6_operands", 32'(operands), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      send_instr(8'hE1, 8'hE2);
      chk("t6_new_op", 32'(opcode), 32'hE1);
      chk("t6_new_opd", 32'(operands), 32'hE2);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
Parameterised successor to the single-slot instruction register. It assembles multi-field instructions from a byte/word stream coming off the MDR and buffers complete instructions in a small prefetch queue. The decode/control unit consumes instructions through a valid/ready handshake. It sits between the memory data register and the control FSM, and supports a pipeline flush for branches.

Parameters:
DATA_W, 8, width of one instruction field (one MDR word)
FIELDS, 2, fields per instruction (field 0 = opcode, fields 1..FIELDS-1 = operands); legal range 2..4
DEPTH, 4, number of complete-instruction slots in the queue; power of 2, at least 2

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
mdr  input  DATA_W  incoming instruction field
mdr_valid  input  1  mdr holds a field to load
mdr_ready  output  1  block accepts mdr this cycle
flush  input  1  synchronous discard of queue and partial assembly
opcode  output  DATA_W  field 0 of head instruction
operands  output  (FIELDS-1)*DATA_W  fields 1..FIELDS-1 of head instruction; field 1 in LSBs
instr_valid  output  1  head instruction present
instr_ready  input  1  consumer takes head instruction
count  output  $clog2(DEPTH+1)  complete instructions held
partial  output  1  assembly index non-zero (fields pending)

Behaviour:
- Reset (reset_n low, asynchronous):
  - Assembly index, read/write pointers and count go to 0.
  - opcode, operands and partial go to 0; instr_valid goes to 0.
  - Assembly and queue storage need not be cleared.
- Assembly:
  - The index idx counts 0..FIELDS-1.
  - A field is accepted on a rising edge when mdr_valid & mdr_ready; mdr is stored in field slot idx.
  - If idx < FIELDS-1, idx increments.
  - If idx == FIELDS-1, the full instruction (stored fields plus the current mdr as the last field) is written into the queue slot at wptr on that same edge. wptr increments (wraps modulo DEPTH) and idx returns to 0.
- Back-pressure: mdr_ready = NOT (idx == FIELDS-1 AND count == DEPTH).
  - Non-final fields are accepted even when the queue is full.
  - mdr_ready has no combinational dependency on instr_ready; a same-cycle pop does not free space for a push.
- Output:
  - instr_valid = (count != 0).
  - opcode/operands combinationally reflect the slot at rptr when instr_valid = 1, and are forced to 0 when instr_valid = 0.
  - Pop occurs on an edge when instr_valid & instr_ready; rptr increments (wraps).
  - instr_ready while empty has no effect.
- Count: push only gives +1, pop only gives -1, push and pop together leave count unchanged. count never exceeds DEPTH.
- Latency: the final field accepted at edge N gives instr_valid = 1 in the cycle after edge N (queue was empty). Sustained throughput is one instruction per FIELDS cycles.
- Flush (synchronous, highest priority): on an edge with flush = 1, idx, rptr, wptr and count all clear.
  - Any mdr accept and any pop in that cycle are ignored.
  - mdr_ready keeps its normal value during flush, but no state updates.
- Reset mid-assembly or mid-pop: asynchronous clear as above; the first accepted field after release is treated as field 0.
- partial = (idx != 0).

Test Plan:
- Reset then single instruction (defaults): mdr 0x3A then 0x05 with mdr_valid on consecutive cycles, instr_ready = 0.
  - Required: after the second edge, instr_valid = 1, opcode = 0x3A, operands = 0x05, count = 1, partial = 0. Between the two edges, partial = 1 and opcode = 0.
- Fill and back-pressure: push 4 instructions (opcodes 0x10..0x13), then present opcode 0x14.
  - Required: 0x14 is accepted (partial = 1) and mdr_ready = 0 on its operand.
  - After one pop, mdr_ready = 1, the operand is accepted, count returns to 4, and heads come out in order 0x11..0x14.
- Simultaneous push and pop at count = 2: the final field is accepted on the same edge as instr_ready = 1.
  - Required: count stays 2, the head advances to the next instruction, and the new instruction sits at the tail.
- Wrap-around: stream 10 instructions with instr_ready held at 1 and DEPTH = 4.
  - Required: all 10 opcodes emerge in order with no loss or duplication, and count never exceeds 1.
- Flush mid-assembly: queue holds 2 instructions, opcode 0x22 accepted, flush = 1 together with mdr_valid = 1 (operand 0x99) and instr_ready = 1.
  - Required: next cycle count = 0, instr_valid = 0, partial = 0, opcode = 0.
  - A following 0x40, 0x01 pair appears as opcode 0x40, operand 0x01.
- Async reset mid-operation: assert reset_n = 0 between clock edges with count = 3 and partial = 1.
  - Required: instr_valid, count, partial, opcode and operands go to 0 immediately, without waiting for a clock edge. After release, the first accepted field becomes the opcode.
